// File: rtl/iob_timer_sampler.sv
// Bus-master front end for iob_timer: on each trigger it stops the timer, reads the 64-bit
// count (high word, then low word) and queues {id, timestamp} in a FIFO for a host to pop.
module iob_timer_sampler #(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic [ID_W-1:0]    trig_id,
  input  logic               clr,
  output logic               tmr_valid,
  output logic [1:0]         tmr_addr,
  output logic [31:0]        tmr_wdata,
  input  logic [31:0]        tmr_rdata,
  input  logic               tmr_ready,
  output logic               out_valid,
  output logic [63:0]        out_ts,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   level,
  output logic               ovf,
  input  logic               ovf_clr
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic [2:0] {StIdle, StStop, StG1, StHi, StG2, StLo, StClr} state_e;

  state_e              state_q;
  logic                tmr_valid_q;
  logic [1:0]          tmr_addr_q;
  logic [31:0]         tmr_wdata_q;
  logic [ID_W-1:0]     id_q;
  logic [31:0]         hi_q;

  logic                pend_trig_q;
  logic [ID_W-1:0]     pend_id_q;
  logic                pend_clr_q;
  logic                ovf_q;

  logic [ID_W+63:0]    mem [Depth];
  logic [FIFO_AW-1:0]  wptr_q, rptr_q;
  logic [FIFO_AW:0]    count_q;

  logic hs, consume, push_req, push_ok, pop, full, trig_drop, push_drop;

  // tmr_ready is only meaningful while a request is outstanding.
  assign hs        = tmr_valid_q & tmr_ready;
  assign consume   = (state_q == StIdle) & ~pend_clr_q & pend_trig_q;
  assign push_req  = (state_q == StLo) & hs;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == (FIFO_AW + 1)'(Depth));
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & ~push_ok;
  assign trig_drop = trig & pend_trig_q & ~consume;

  assign tmr_valid = tmr_valid_q;
  assign tmr_addr  = tmr_addr_q;
  assign tmr_wdata = tmr_wdata_q;
  assign level     = count_q;
  assign ovf       = ovf_q;
  assign {out_id, out_ts} = mem[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmr_valid_q <= 1'b0;
      tmr_addr_q  <= 2'd0;
      tmr_wdata_q <= 32'd0;
      id_q        <= '0;
      hi_q        <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend_clr_q) begin
            state_q     <= StClr;
            tmr_valid_q <= 1'b1;
            tmr_addr_q  <= 2'd0;
            tmr_wdata_q <= 32'd1;
          end else if (pend_trig_q) begin
            state_q     <= StStop;
            tmr_valid_q <= 1'b1;
            tmr_addr_q  <= 2'd1;
            tmr_wdata_q <= 32'd0;
            id_q        <= pend_id_q;
          end
        end
        StStop: begin
          if (hs) begin
            state_q     <= StG1;
            tmr_valid_q <= 1'b0;
          end
        end
        // Gap cycles swallow the stale tmr_ready that follows every handshake.
        StG1: begin
          state_q     <= StHi;
          tmr_valid_q <= 1'b1;
          tmr_addr_q  <= 2'd2;
        end
        StHi: begin
          if (hs) begin
            hi_q        <= tmr_rdata;
            state_q     <= StG2;
            tmr_valid_q <= 1'b0;
          end
        end
        StG2: begin
          state_q     <= StLo;
          tmr_valid_q <= 1'b1;
          tmr_addr_q  <= 2'd3;
        end
        StLo: begin
          if (hs) begin
            state_q     <= StIdle;
            tmr_valid_q <= 1'b0;
          end
        end
        StClr: begin
          if (hs) begin
            state_q     <= StIdle;
            tmr_valid_q <= 1'b0;
            tmr_wdata_q <= 32'd0;
          end
        end
        default: begin
          state_q     <= StIdle;
          tmr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_trig_q <= 1'b0;
      pend_id_q   <= '0;
      pend_clr_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (trig && (!pend_trig_q || consume)) begin
        pend_trig_q <= 1'b1;
        pend_id_q   <= trig_id;
      end else if (consume) begin
        pend_trig_q <= 1'b0;
      end
      if (clr) begin
        pend_clr_q <= 1'b1;
      end else if ((state_q == StClr) && hs) begin
        pend_clr_q <= 1'b0;
      end
      ovf_q <= (ovf_q & ~ovf_clr) | trig_drop | push_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= {id_q, hi_q, tmr_rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + FIFO_AW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + (FIFO_AW + 1)'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - (FIFO_AW + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_iob_timer_sampler.sv
// Directed bench for iob_timer_sampler with a small free-running timer model on the bus side.
module tb_iob_timer_sampler;

  localparam int ID_W    = 4;
  localparam int FIFO_AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              trig;
  logic [ID_W-1:0]   trig_id;
  logic              clr;
  logic              tmr_valid;
  logic [1:0]        tmr_addr;
  logic [31:0]       tmr_wdata;
  logic [31:0]       tmr_rdata;
  logic              tmr_ready;
  logic              out_valid;
  logic [63:0]       out_ts;
  logic [ID_W-1:0]   out_id;
  logic              out_ready;
  logic [FIFO_AW:0]  level;
  logic              ovf;
  logic              ovf_clr;

  iob_timer_sampler #(.ID_W(ID_W), .FIFO_AW(FIFO_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .trig_id   (trig_id),
    .clr       (clr),
    .tmr_valid (tmr_valid),
    .tmr_addr  (tmr_addr),
    .tmr_wdata (tmr_wdata),
    .tmr_rdata (tmr_rdata),
    .tmr_ready (tmr_ready),
    .out_valid (out_valid),
    .out_ts    (out_ts),
    .out_id    (out_id),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Timer model: free-running count, STOP snapshots it, RESET zeroes it, ready = valid delayed.
  logic [63:0] cnt;
  logic [63:0] cap;
  logic [1:0]  hs_addr [$];
  logic [31:0] hs_wdata [$];

  initial begin
    cnt       = 64'h0000_0002_FFFF_FFFC;
    cap       = 64'd0;
    tmr_ready = 1'b0;
  end

  assign tmr_rdata = (tmr_addr == 2'd2) ? cap[63:32] : cap[31:0];

  always @(posedge clk) begin
    cnt       <= cnt + 64'd1;
    tmr_ready <= tmr_valid;
    if (tmr_valid && tmr_ready) begin
      hs_addr.push_back(tmr_addr);
      hs_wdata.push_back(tmr_wdata);
      if (tmr_addr == 2'd0 && tmr_wdata == 32'd1) cnt <= 64'd0;
      if (tmr_addr == 2'd1) cap <= cnt;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input logic [ID_W-1:0] id, input logic [63:0] ts);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_id"}, 64'(out_id), 64'(id));
    check({tag, "_ts"}, out_ts, ts);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic pulse_trig(input logic [ID_W-1:0] id);
    trig    = 1'b1;
    trig_id = id;
    tick(1);
    trig    = 1'b0;
  endtask

  logic [63:0] c0, t1, t2;
  int          n0;

  initial begin
    rst = 1'b1; trig = 1'b0; trig_id = '0; clr = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    check("rst_valid", 64'(tmr_valid), 64'd0);
    check("rst_addr", 64'(tmr_addr), 64'd0);
    check("rst_wdata", 64'(tmr_wdata), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick(2);

    // 1: single trigger, latency and timestamp
    c0 = cnt;
    pulse_trig(4'd5);
    check("t1_valid_T1", 64'(tmr_valid), 64'd0);
    tick(1);
    check("t1_stop_valid", 64'(tmr_valid), 64'd1);
    check("t1_stop_addr", 64'(tmr_addr), 64'd1);
    check("t1_stop_wdata", 64'(tmr_wdata), 64'd0);
    tick(7);
    check("t1_out_valid_T9", 64'(out_valid), 64'd0);
    tick(1);
    check("t1_level", 64'(level), 64'd1);
    pop_check("t1", 4'd5, c0 + 64'd3);
    check("t1_level_after_pop", 64'(level), 64'd0);
    check("t1_out_valid_after_pop", 64'(out_valid), 64'd0);

    // 2: two triggers 20 cycles apart
    tick(3);
    c0 = cnt;
    pulse_trig(4'd1);
    tick(19);
    pulse_trig(4'd2);
    tick(12);
    check("t2_level", 64'(level), 64'd2);
    t1 = out_ts;
    pop_check("t2_a", 4'd1, c0 + 64'd3);
    t2 = out_ts;
    pop_check("t2_b", 4'd2, c0 + 64'd23);
    check("t2_diff", t2 - t1, 64'd20);

    // 3: back-to-back triggers overflow the pending slot
    tick(3);
    c0 = cnt;
    pulse_trig(4'd3);
    pulse_trig(4'd4);
    pulse_trig(4'd6);
    tick(25);
    check("t3_level", 64'(level), 64'd2);
    check("t3_ovf", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", 64'(ovf), 64'd0);
    pop_check("t3_a", 4'd3, c0 + 64'd3);
    pop_check("t3_b", 4'd4, c0 + 64'd12);

    // 4: FIFO full, ninth sample dropped, head held
    tick(3);
    c0 = cnt;
    for (int i = 0; i < 9; i++) begin
      pulse_trig(ID_W'(i));
      tick(11);
    end
    check("t4_level", 64'(level), 64'd8);
    check("t4_ovf", 64'(ovf), 64'd1);
    check("t4_head_id", 64'(out_id), 64'd0);
    check("t4_head_ts", out_ts, c0 + 64'd3);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop_check($sformatf("t4_drain%0d", i), ID_W'(i), c0 + 64'(12 * i + 3));
    end
    check("t4_level_empty", 64'(level), 64'd0);

    // 5: clr and trig together, reset write goes first
    tick(2);
    n0 = hs_addr.size();
    clr = 1'b1;
    pulse_trig(4'd9);
    clr = 1'b0;
    tick(14);
    check("t5_hs_count", 64'(hs_addr.size() - n0), 64'd4);
    if (hs_addr.size() >= n0 + 4) begin
      check("t5_hs0_addr", 64'(hs_addr[n0]), 64'd0);
      check("t5_hs0_wdata", 64'(hs_wdata[n0]), 64'd1);
      check("t5_hs1_addr", 64'(hs_addr[n0 + 1]), 64'd1);
      check("t5_hs1_wdata", 64'(hs_wdata[n0 + 1]), 64'd0);
      check("t5_hs2_addr", 64'(hs_addr[n0 + 2]), 64'd2);
      check("t5_hs3_addr", 64'(hs_addr[n0 + 3]), 64'd3);
    end
    check("t5_level", 64'(level), 64'd1);
    check("t5_id", 64'(out_id), 64'd9);
    check("t5_ts", out_ts, 64'd2);

    // 6: asynchronous reset while reading DATA_HIGH
    pulse_trig(4'd7);
    tick(4);
    check("t6_in_hi_valid", 64'(tmr_valid), 64'd1);
    check("t6_in_hi_addr", 64'(tmr_addr), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(tmr_valid), 64'd0);
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("t6_idle_valid", 64'(tmr_valid), 64'd0);
    c0 = cnt;
    pulse_trig(4'd10);
    tick(9);
    check("t6_level", 64'(level), 64'd1);
    pop_check("t6_after", 4'd10, c0 + 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
